serial_ripple_subtractor: RTL and testbench



---
 rtl/serial_ripple_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell with a registered borrow
// computes {borrow, a - b} LSB first, one bit per clock, with a valid/ack handshake.
module serial_ripple_subtractor #(
  parameter int WIDTH = 2,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [WIDTH:0]   o_diff
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   diff;
  logic             ready;
  logic             valid;

  logic             a_bit;
  logic             b_bit;
  logic [1:0]       fs;
  logic             last;
  logic [WIDTH:0]   diff_upd;

  // Returns {borrow_out, difference} of a - b - borrow_in.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  // Select the current operand bits and fold the cell result into the difference.
  always_comb begin
    a_bit    = 1'b0;
    b_bit    = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      a_bit = a_bit | (a_reg[k] & (cnt == CNT_W'(k)));
      b_bit = b_bit | (b_reg[k] & (cnt == CNT_W'(k)));
    end
    fs       = full_sub(a_bit, b_bit, borrow);
    last     = (cnt == LAST_BIT);
    diff_upd = diff;
    for (int k = 0; k < WIDTH; k++) begin
      diff_upd[k] = (cnt == CNT_W'(k)) ? fs[0] : diff[k];
    end
    // The final borrow becomes the sign/borrow bit of the result.
    diff_upd[WIDTH] = last ? fs[1] : diff[WIDTH];
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        if (i_ack) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand, borrow, counter, result and handshake registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_reg  <= {WIDTH{1'b0}};
      b_reg  <= {WIDTH{1'b0}};
      borrow <= 1'b0;
      cnt    <= {CNT_W{1'b0}};
      diff   <= {(WIDTH + 1){1'b0}};
      ready  <= 1'b1;
      valid  <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
      valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg  <= i_minuend;
            b_reg  <= i_subtrahend;
            borrow <= 1'b0;
            cnt    <= {CNT_W{1'b0}};
            diff   <= {(WIDTH + 1){1'b0}};
          end else begin
            a_reg  <= a_reg;
            b_reg  <= b_reg;
            borrow <= borrow;
            cnt    <= cnt;
            diff   <= diff;
          end
        end
        SHIFT: begin
          borrow <= fs[1];
          diff   <= diff_upd;
          // The counter parks on the last bit rather than wrapping.
          cnt    <= last ? cnt : cnt + CNT_W'(1);
        end
        default: begin
          diff <= diff;
        end
      endcase
    end
  end

  assign o_ready = ready;
  assign o_valid = valid;
  assign o_diff  = diff;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: WIDTH=2 and WIDTH=8 instances checked every
// cycle against an arithmetic/latency model, plus directed literal expectations.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       vld [2];
  logic       ack [2];
  logic [7:0] opa [2];
  logic [7:0] opb [2];

  logic       rdy2, ov2, rdy8, ov8;
  logic [2:0] dif2;
  logic [8:0] dif8;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  serial_ripple_subtractor #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst[0]), .i_valid(vld[0]), .o_ready(rdy2),
    .i_minuend(opa[0][1:0]), .i_subtrahend(opb[0][1:0]),
    .o_valid(ov2), .i_ack(ack[0]), .o_diff(dif2)
  );

  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst[1]), .i_valid(vld[1]), .o_ready(rdy8),
    .i_minuend(opa[1]), .i_subtrahend(opb[1]),
    .o_valid(ov8), .i_ack(ack[1]), .o_diff(dif8)
  );

  function automatic int wid(input int i);
    return (i == 0) ? 2 : 8;
  endfunction

  function automatic logic get_rdy(input int i);
    return (i == 0) ? rdy2 : rdy8;
  endfunction

  function automatic logic get_ov(input int i);
    return (i == 0) ? ov2 : ov8;
  endfunction

  function automatic logic [8:0] get_dif(input int i);
    return (i == 0) ? {6'b000000, dif2} : dif8;
  endfunction

  // {0,a} - {0,b} modulo 2^(W+1)
  function automatic logic [8:0] ref_diff(input int i, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] rmask;
    logic [8:0] omask;
    rmask = (9'h001 << (wid(i) + 1)) - 9'h001;
    omask = (9'h001 << wid(i)) - 9'h001;
    return ({1'b0, a & omask[7:0]} - {1'b0, b & omask[7:0]}) & rmask;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: request accepted when idle, result due W edges later, held until ack.
  bit         m_ready [2];
  bit         m_valid [2];
  bit         m_pend  [2];
  bit         m_known [2];
  int         m_fin   [2];
  logic [8:0] m_res   [2];
  logic [8:0] m_diff  [2];
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_ready[i] <= 1'b1; m_valid[i] <= 1'b0; m_pend[i] <= 1'b0;
        m_diff[i]  <= 9'h000; m_known[i] <= 1'b1;
      end else if (m_ready[i] && vld[i]) begin
        m_ready[i] <= 1'b0; m_pend[i] <= 1'b1; m_known[i] <= 1'b0;
        m_fin[i]   <= cyc + wid(i);
        m_res[i]   <= ref_diff(i, opa[i], opb[i]);
      end else if (m_pend[i] && cyc == m_fin[i]) begin
        m_pend[i]  <= 1'b0; m_valid[i] <= 1'b1;
        m_diff[i]  <= m_res[i]; m_known[i] <= 1'b1;
      end else if (m_valid[i] && ack[i]) begin
        m_valid[i] <= 1'b0; m_ready[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_ready%0d", wid(i)), {8'h00, get_rdy(i)}, {8'h00, m_ready[i]});
        check($sformatf("model_valid%0d", wid(i)), {8'h00, get_ov(i)}, {8'h00, m_valid[i]});
        if (m_known[i]) begin
          check($sformatf("model_diff%0d", wid(i)), get_dif(i), m_diff[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int i, output int k);
    k = 0;
    while (!get_ov(i) && k < 30) begin
      tick();
      k++;
    end
  endtask

  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp, input bit pin, input string name);
    int k;
    if (pin) check({name, "_model"}, ref_diff(i, a, b), exp);
    vld[i] = 1'b1; opa[i] = a; opb[i] = b;
    tick();
    vld[i] = 1'b0;
    wait_valid(i, k);
    check({name, "_latency"}, 9'(k), 9'(wid(i)));
    check(name, get_dif(i), exp);
    ack[i] = 1'b1;
    tick();
    ack[i] = 1'b0;
  endtask

  initial begin
    int  k;
    int  n;
    bit  acked;
    bit  seen;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; ack[i] = 1'b0; opa[i] = 8'h00; opb[i] = 8'h00;
    end
    tick();
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_en = 1'b1;
    check("rst_ready2", {8'h00, rdy2}, 9'h001);
    check("rst_valid2", {8'h00, ov2}, 9'h000);
    check("rst_diff2", {6'b000000, dif2}, 9'h000);
    check("rst_ready8", {8'h00, rdy8}, 9'h001);
    check("rst_diff8", dif8, 9'h000);

    run_op(0, 8'h03, 8'h01, 9'b010, 1'b1, "w2_3m1");
    run_op(0, 8'h01, 8'h03, 9'b110, 1'b1, "w2_1m3");
    run_op(0, 8'h00, 8'h00, 9'b000, 1'b1, "w2_0m0");
    run_op(0, 8'h02, 8'h01, 9'b001, 1'b1, "w2_2m1");

    // Result held while unacknowledged; new requests ignored.
    vld[0] = 1'b1; opa[0] = 8'h03; opb[0] = 8'h02;
    tick();
    vld[0] = 1'b0;
    wait_valid(0, k);
    for (int j = 0; j < 5; j++) begin
      vld[0] = (j % 2 == 0); opa[0] = 8'(j); opb[0] = 8'(3 - j);
      tick();
      check("hold_diff", {6'b000000, dif2}, 9'b001);
      check("hold_valid", {8'h00, ov2}, 9'h001);
      check("hold_ready", {8'h00, rdy2}, 9'h000);
    end
    vld[0] = 1'b0; ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    check("ack_ready", {8'h00, rdy2}, 9'h001);
    check("ack_valid", {8'h00, ov2}, 9'h000);
    check("ack_diff_kept", {6'b000000, dif2}, 9'b001);

    // Back-to-back with i_valid held high.
    vld[0] = 1'b1; opa[0] = 8'h01; opb[0] = 8'h00;
    tick();
    n = 0; acked = 1'b0; seen = 1'b0;
    while (n < 30) begin
      tick();
      n++;
      if (ack[0]) ack[0] = 1'b0;
      if (ov2 && !acked) begin
        ack[0] = 1'b1; acked = 1'b1;
        check("b2b_first", {6'b000000, dif2}, 9'b001);
      end
      if (rdy2) begin
        seen = 1'b1; opa[0] = 8'h00; opb[0] = 8'h01;
      end else if (seen) begin
        break;
      end
    end
    vld[0] = 1'b0;
    check("b2b_spacing", 9'(n), 9'd4);
    wait_valid(0, k);
    check("b2b_second", {6'b000000, dif2}, 9'b111);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;

    // Reset in the middle of SHIFT.
    vld[1] = 1'b1; opa[1] = 8'h80; opb[1] = 8'h01;
    tick();
    vld[1] = 1'b0;
    tick();
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check("midrst_valid", {8'h00, ov8}, 9'h000);
    check("midrst_diff", dif8, 9'h000);
    check("midrst_ready", {8'h00, rdy8}, 9'h001);
    run_op(1, 8'h80, 8'h01, 9'h07F, 1'b1, "w8_80m01");
    run_op(1, 8'h00, 8'h01, 9'h1FF, 1'b1, "w8_00m01");
    run_op(1, 8'hFF, 8'hFF, 9'h000, 1'b1, "w8_FFmFF");
    run_op(1, 8'h5A, 8'hA5, 9'h1B5, 1'b1, "w8_5AmA5");

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        run_op(0, 8'(a), 8'(b), ref_diff(0, 8'(a), 8'(b)), 1'b0, "sweep");
      end
    end

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
